// File: rtl/mac4_feeder.sv
// Operand sequencer feeding a 4-lane MAC: streams N feature/weight groups, steers acc, captures the sum.
// Optional bubble counter enabled by defining MAC4_FEEDER_STALL_CNT_EN.
module mac4_feeder #(
  parameter int FEAT_WIDTH   = 8,
  parameter int WGT_WIDTH    = 8,
  parameter int PE_OUT_WIDTH = 16,
  parameter int LEN_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    vec_len,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*FEAT_WIDTH-1:0] in_a,
  input  logic [4*WGT_WIDTH-1:0]  in_b,
  output logic [4*FEAT_WIDTH-1:0] mac_a,
  output logic [4*WGT_WIDTH-1:0]  mac_b,
  output logic                    mac_acc,
  output logic [FEAT_WIDTH-1:0]   mac_c1,
  input  logic [PE_OUT_WIDTH-1:0] mac_sum,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PE_OUT_WIDTH-1:0] out_data,
  output logic [15:0]             stall_cnt
);

  typedef enum logic [2:0] {IDLE, RUN, FLUSH, CAPT, HOLD} state_t;

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] cnt_q;
  logic [LEN_WIDTH-1:0] cnt_inc;
  logic                 beat;
  logic                 job_go;

  assign beat      = (state == RUN) && in_valid;
  assign job_go    = (state == IDLE) && start;
  assign cnt_inc   = cnt_q + 1'b1;
  assign busy      = (state != IDLE);
  assign in_ready  = (state == RUN);
  assign out_valid = (state == HOLD);
  assign mac_c1    = '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (vec_len != '0) ? RUN : HOLD;
      RUN:     if (beat && (cnt_inc == len_q)) state_nxt = FLUSH;
      FLUSH:   state_nxt = CAPT;
      CAPT:    state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      mac_a    <= '0;
      mac_b    <= '0;
      mac_acc  <= 1'b1;
      out_data <= '0;
    end else begin
      state <= state_nxt;

      if (job_go) begin
        len_q <= vec_len;
        cnt_q <= '0;
      end else if (beat) begin
        cnt_q <= cnt_inc;
      end

      // MAC has no enable: idle cycles feed zeros with acc=1 so its sum holds.
      if (beat) begin
        mac_a   <= in_a;
        mac_b   <= in_b;
        mac_acc <= (cnt_q != '0);
      end else begin
        mac_a   <= '0;
        mac_b   <= '0;
        mac_acc <= 1'b1;
      end

      if (job_go && (vec_len == '0)) out_data <= '0;
      else if (state == CAPT)        out_data <= mac_sum;
    end
  end

`ifdef MAC4_FEEDER_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (job_go) begin
      stall_q <= '0;
    end else if ((state == RUN) && !in_valid && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
